fp_normalize_seq: RTL and testbench

FP_NORMALIZE_SEQ -- requirements
Module: fp_normalize_seq

---
 rtl/fp_pkg.sv | 34 +++
 rtl/fp_normalize_seq.sv | 129 ++++++++++++
 tb/tb_fp_normalize_seq.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point normalization stage:
// default field widths, FSM state encoding and the normalized-result record.
package fp_pkg;

    localparam int FP_EXP_W  = 8;
    localparam int FP_MANT_W = 24;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } norm_state_e;

    typedef struct packed {
        logic zero;
        logic overflow;
        logic underflow;
        logic sticky;
    } norm_flags_t;

    typedef struct packed {
        logic                 sign;
        logic [FP_EXP_W-1:0]  exp;
        logic [FP_MANT_W-1:0] mant;
        norm_flags_t          flags;
    } norm_result_t;

    function automatic norm_flags_t flags_clear();
        norm_flags_t f;
        f = '{zero: 1'b0, overflow: 1'b0, underflow: 1'b0, sticky: 1'b0};
        return f;
    endfunction

endpackage

// File: rtl/fp_normalize_seq.sv
// Sequential post-add normalizer: fixes carry-out in one step, or left-shifts
// one bit per cycle until the hidden bit is set, then holds the result.
module fp_normalize_seq
    import fp_pkg::*;
#(
    parameter int EXP_W  = FP_EXP_W,
    parameter int MANT_W = FP_MANT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [MANT_W:0]   in_mant,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sign,
    output logic [EXP_W-1:0]  out_exp,
    output logic [MANT_W-1:0] out_mant,
    output logic              out_zero,
    output logic              out_overflow,
    output logic              out_underflow,
    output logic              out_sticky
);

    localparam logic [EXP_W-1:0] EXP_ONE  = EXP_W'(1);
    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    // A carry from this exponent or above would reach all-ones (or wrap).
    localparam logic [EXP_W-1:0] EXP_OVF  = EXP_ONES - EXP_ONE;

    norm_state_e       state_q, state_d;
    logic              sign_q,  sign_d;
    logic [EXP_W-1:0]  exp_q,   exp_d;
    logic [MANT_W-1:0] mant_q,  mant_d;
    norm_flags_t       flags_q, flags_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sign_q  <= 1'b0;
            exp_q   <= '0;
            mant_q  <= '0;
            flags_q <= flags_clear();
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            exp_q   <= exp_d;
            mant_q  <= mant_d;
            flags_q <= flags_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        exp_d   = exp_q;
        mant_d  = mant_q;
        flags_d = flags_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    sign_d  = in_sign;
                    flags_d = flags_clear();
                    state_d = ST_HOLD;
                    if (in_mant == '0) begin
                        exp_d        = '0;
                        mant_d       = '0;
                        flags_d.zero = 1'b1;
                    end else if (in_mant[MANT_W]) begin
                        flags_d.sticky = in_mant[0];
                        if (in_exp >= EXP_OVF) begin
                            exp_d            = EXP_ONES;
                            mant_d           = '0;
                            flags_d.overflow = 1'b1;
                        end else begin
                            exp_d  = in_exp + EXP_ONE;
                            mant_d = in_mant[MANT_W:1];
                        end
                    end else begin
                        // Subnormal and already-normalized inputs pass through.
                        exp_d  = in_exp;
                        mant_d = in_mant[MANT_W-1:0];
                        if ((in_exp != '0) && !in_mant[MANT_W-1]) begin
                            state_d = ST_SHIFT;
                        end
                    end
                end
            end

            ST_SHIFT: begin
                if (exp_q <= EXP_ONE) begin
                    // No room left to shift: flush to the subnormal exponent.
                    exp_d             = '0;
                    flags_d.underflow = 1'b1;
                    state_d           = ST_HOLD;
                end else begin
                    mant_d = {mant_q[MANT_W-2:0], 1'b0};
                    exp_d  = exp_q - EXP_ONE;
                    if (mant_q[MANT_W-2]) begin
                        state_d = ST_HOLD;
                    end
                end
            end

            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign in_ready      = (state_q == ST_IDLE) && rst_n;
    assign out_valid     = (state_q == ST_HOLD);
    assign out_sign      = sign_q;
    assign out_exp       = exp_q;
    assign out_mant      = mant_q;
    assign out_zero      = flags_q.zero;
    assign out_overflow  = flags_q.overflow;
    assign out_underflow = flags_q.underflow;
    assign out_sticky    = flags_q.sticky;

endmodule

// File: tb/tb_fp_normalize_seq.sv
// Directed bench for fp_normalize_seq: a vector table with hand-computed
// results and latencies, plus backpressure and mid-shift reset sequences.
module tb_fp_normalize_seq;
    import fp_pkg::*;

    localparam int EW = FP_EXP_W;
    localparam int MW = FP_MANT_W;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_sign = 1'b0;
    logic [EW-1:0] in_exp = '0;
    logic [MW:0]   in_mant = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_sign;
    logic [EW-1:0] out_exp;
    logic [MW-1:0] out_mant;
    logic          out_zero, out_overflow, out_underflow, out_sticky;

    int checks = 0;
    int errors = 0;

    fp_normalize_seq #(.EXP_W(EW), .MANT_W(MW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sign      (in_sign),
        .in_exp       (in_exp),
        .in_mant      (in_mant),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sign     (out_sign),
        .out_exp      (out_exp),
        .out_mant     (out_mant),
        .out_zero     (out_zero),
        .out_overflow (out_overflow),
        .out_underflow(out_underflow),
        .out_sticky   (out_sticky)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         name;
        logic          sign;
        logic [EW-1:0] exp;
        logic [MW:0]   mant;
        int            lat;
        norm_result_t  res;
    } vec_t;

    vec_t vecs[$];

    function automatic norm_result_t mk(input logic s, input logic [EW-1:0] e,
                                        input logic [MW-1:0] m, input logic z,
                                        input logic o, input logic u, input logic st);
        norm_result_t r;
        r.sign            = s;
        r.exp             = e;
        r.mant            = m;
        r.flags.zero      = z;
        r.flags.overflow  = o;
        r.flags.underflow = u;
        r.flags.sticky    = st;
        return r;
    endfunction

    function automatic void add_vec(input string n, input logic s, input logic [EW-1:0] e,
                                    input logic [MW:0] m, input int lat, input norm_result_t r);
        vec_t v;
        v.name = n; v.sign = s; v.exp = e; v.mant = m; v.lat = lat; v.res = r;
        vecs.push_back(v);
    endfunction

    function automatic norm_result_t actual();
        return mk(out_sign, out_exp, out_mant, out_zero, out_overflow, out_underflow, out_sticky);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Called at a falling edge with the DUT idle; returns at a falling edge.
    task automatic run_vec(input vec_t v);
        int  lat;
        bit  got;
        check({v.name, " in_ready"}, 64'(in_ready), 64'(1));
        in_valid = 1'b1; in_sign = v.sign; in_exp = v.exp; in_mant = v.mant;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            if (out_valid) got = 1'b1;
        end
        check({v.name, " latency"}, 64'(lat), 64'(v.lat));
        check({v.name, " result"}, 64'(actual()), 64'(v.res));
        $display("vec %s: lat=%0d exp=%0h mant=%0h flags=%b", v.name, lat, out_exp, out_mant,
                 {out_zero, out_overflow, out_underflow, out_sticky});
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check({v.name, " out_valid after handshake"}, 64'(out_valid), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        norm_result_t held;

        add_vec("carry",        1'b0, 8'h80, 25'h1800000, 1,  mk(1'b0, 8'h81, 24'hC00000, 0, 0, 0, 0));
        add_vec("carry_sticky", 1'b0, 8'h10, 25'h1000001, 1,  mk(1'b0, 8'h11, 24'h800000, 0, 0, 0, 1));
        add_vec("shift3",       1'b0, 8'h7F, 25'h0100000, 4,  mk(1'b0, 8'h7C, 24'h800000, 0, 0, 0, 0));
        add_vec("zero",         1'b1, 8'h85, 25'h0000000, 1,  mk(1'b1, 8'h00, 24'h000000, 1, 0, 0, 0));
        add_vec("overflow",     1'b0, 8'hFE, 25'h1800000, 1,  mk(1'b0, 8'hFF, 24'h000000, 0, 1, 0, 0));
        add_vec("underflow",    1'b0, 8'h03, 25'h0000001, 4,  mk(1'b0, 8'h00, 24'h000004, 0, 0, 1, 0));
        add_vec("subnormal",    1'b0, 8'h00, 25'h0000123, 1,  mk(1'b0, 8'h00, 24'h000123, 0, 0, 0, 0));
        add_vec("normalized",   1'b1, 8'h40, 25'h0A5A5A5, 1,  mk(1'b1, 8'h40, 24'hA5A5A5, 0, 0, 0, 0));
        add_vec("shift1",       1'b1, 8'h20, 25'h0400000, 2,  mk(1'b1, 8'h1F, 24'h800000, 0, 0, 0, 0));
        add_vec("shift_max",    1'b0, 8'h7F, 25'h0000001, 24, mk(1'b0, 8'h68, 24'h800000, 0, 0, 0, 0));
        add_vec("unf_exp1",     1'b0, 8'h01, 25'h0400000, 2,  mk(1'b0, 8'h00, 24'h400000, 0, 0, 1, 0));
        add_vec("shift_to_e1",  1'b0, 8'h02, 25'h0400000, 2,  mk(1'b0, 8'h01, 24'h800000, 0, 0, 0, 0));
        add_vec("zero_exp0",    1'b0, 8'h00, 25'h0000000, 1,  mk(1'b0, 8'h00, 24'h000000, 1, 0, 0, 0));

        // Reset state, then accept on the first rising edge after release.
        repeat (2) @(negedge clk);
        check("reset outputs", 64'(actual()), 64'(0));
        check("reset out_valid", 64'(out_valid), 64'(0));
        check("reset in_ready", 64'(in_ready), 64'(0));
        rst_n = 1'b1;
        #1;
        foreach (vecs[i]) run_vec(vecs[i]);

        // Backpressure: result held for 5 cycles while a new input is offered.
        in_valid = 1'b1; in_sign = 1'b0; in_exp = 8'h80; in_mant = 25'h1800000;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        held = mk(1'b0, 8'h81, 24'hC00000, 0, 0, 0, 0);
        check("bp out_valid", 64'(out_valid), 64'(1));
        check("bp result", 64'(actual()), 64'(held));
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1; in_sign = 1'b1; in_exp = 8'h11; in_mant = 25'h0400000;
            @(negedge clk);
            check($sformatf("bp cycle%0d result", c), 64'(actual()), 64'(held));
            check($sformatf("bp cycle%0d in_ready", c), 64'(in_ready), 64'(0));
            check($sformatf("bp cycle%0d out_valid", c), 64'(out_valid), 64'(1));
            $display("bp cycle %0d: out_valid=%b in_ready=%b exp=%0h", c, out_valid, in_ready, out_exp);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check($sformatf("bp no ghost %0d", c), 64'(out_valid), 64'(0));
        end

        // Reset pulsed during the second SHIFT cycle of the 3-shift case.
        in_valid = 1'b1; in_sign = 1'b0; in_exp = 8'h7F; in_mant = 25'h0100000;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst mid-shift outputs", 64'(actual()), 64'(0));
        check("rst mid-shift out_valid", 64'(out_valid), 64'(0));
        check("rst mid-shift in_ready", 64'(in_ready), 64'(0));
        $display("reset mid-shift: out_valid=%b exp=%0h mant=%0h", out_valid, out_exp, out_mant);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check($sformatf("rst no out_valid %0d", c), 64'(out_valid), 64'(0));
        end
        run_vec(vecs[2]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
